// File: rtl/vec_dot_loader.sv
// Ping-pong packer: streams lhs/rhs float pairs into VEC_SIZE-element vector buses.
// Element i occupies bits [i*FLOAT_WIDTH +: FLOAT_WIDTH]; released banks are zeroed.
module vec_dot_loader #(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23,
  parameter int          BIAS      = -127,
  parameter int unsigned VEC_SIZE  = 17,
  localparam int unsigned FloatWidth = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int unsigned VecWidth   = VEC_SIZE * FloatWidth,
  localparam int unsigned CountWidth = $clog2(VEC_SIZE + 1),
  localparam int unsigned IdxWidth   = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [FloatWidth-1:0] in_lhs_i,
  input  logic [FloatWidth-1:0] in_rhs_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [VecWidth-1:0]   out_lhs_o,
  output logic [VecWidth-1:0]   out_rhs_o,
  output logic [CountWidth-1:0] out_count_o
);

  // BIAS only travels with the shared vec_* parameter set; nothing here depends on it.
  if (BIAS > 0) begin : g_bias_positive
  end

  typedef logic [VEC_SIZE-1:0][FloatWidth-1:0] bank_t;

  bank_t                 lhs_q [2];
  bank_t                 lhs_d [2];
  bank_t                 rhs_q [2];
  bank_t                 rhs_d [2];
  logic [CountWidth-1:0] cnt_q [2];
  logic [CountWidth-1:0] cnt_d [2];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IdxWidth-1:0]   wr_idx_q, wr_idx_d;

  logic accept, release_bank;

  assign in_ready_o   = ~full_q[wr_bank_q];
  assign out_valid_o  = full_q[rd_bank_q];
  assign accept       = in_valid_i & in_ready_o;
  assign release_bank = out_valid_o & out_ready_i;

  assign out_lhs_o   = out_valid_o ? lhs_q[rd_bank_q] : '0;
  assign out_rhs_o   = out_valid_o ? rhs_q[rd_bank_q] : '0;
  assign out_count_o = out_valid_o ? cnt_q[rd_bank_q] : '0;

  always_comb begin
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;

    if (accept) begin
      lhs_d[wr_bank_q][wr_idx_q] = in_lhs_i;
      rhs_d[wr_bank_q][wr_idx_q] = in_rhs_i;
      if (wr_idx_q == IdxWidth'(VEC_SIZE - 1) || in_last_i) begin
        full_d[wr_bank_q] = 1'b1;
        cnt_d[wr_bank_q]  = CountWidth'(wr_idx_q) + CountWidth'(1);
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IdxWidth'(1);
      end
    end

    // Accept targets a non-full bank and release a full one, so they never collide.
    if (release_bank) begin
      lhs_d[rd_bank_q]  = '0;
      rhs_d[rd_bank_q]  = '0;
      cnt_d[rd_bank_q]  = '0;
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lhs_q     <= '{default: '0};
      rhs_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
    end
  end

endmodule

// File: tb/tb_vec_dot_loader.sv
// Directed + randomized bench for vec_dot_loader against a vector-queue reference model.
module tb_vec_dot_loader;

  localparam int FW = 32;
  localparam int VS = 17;
  localparam int VW = VS * FW;
  localparam int CW = $clog2(VS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last, out_valid, out_ready;
  logic [FW-1:0] in_lhs, in_rhs;
  logic [VW-1:0] out_lhs, out_rhs;
  logic [CW-1:0] out_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [VW-1:0] lhs;
    logic [VW-1:0] rhs;
    int            cnt;
  } vec_t;

  vec_t          pending[$];
  logic [VW-1:0] part_lhs, part_rhs;
  int            part_cnt;

  always #5 clk = ~clk;

  vec_dot_loader dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_lhs_i   (in_lhs),
    .in_rhs_i   (in_rhs),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_lhs_o  (out_lhs),
    .out_rhs_o  (out_rhs),
    .out_count_o(out_count)
  );

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pending.delete();
    part_lhs = '0;
    part_rhs = '0;
    part_cnt = 0;
  endtask

  // Compare every output against the head of the model's completed-vector queue.
  task automatic check_outputs(input string tag);
    logic [VW-1:0] el, er;
    int ec;
    el = '0; er = '0; ec = 0;
    if (pending.size() > 0) begin
      el = pending[0].lhs; er = pending[0].rhs; ec = pending[0].cnt;
    end
    check({tag, ".in_ready"}, 1024'(in_ready), 1024'(pending.size() < 2));
    check({tag, ".out_valid"}, 1024'(out_valid), 1024'(pending.size() > 0));
    check({tag, ".out_count"}, 1024'(out_count), 1024'(ec));
    check({tag, ".out_lhs"}, 1024'(out_lhs), 1024'(el));
    check({tag, ".out_rhs"}, 1024'(out_rhs), 1024'(er));
  endtask

  // One clock: drive inputs, update the model at the edge, check 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [FW-1:0] l,
                      input logic [FW-1:0] r, input logic last, input logic ordy);
    bit acc, rel;
    in_valid = v; in_lhs = l; in_rhs = r; in_last = last; out_ready = ordy;
    @(posedge clk);
    acc = v && (pending.size() < 2);
    rel = ordy && (pending.size() > 0);
    if (rel) void'(pending.pop_front());
    if (acc) begin
      part_lhs[part_cnt*FW +: FW] = l;
      part_rhs[part_cnt*FW +: FW] = r;
      part_cnt++;
      if (part_cnt == VS || last) begin
        pending.push_back('{lhs: part_lhs, rhs: part_rhs, cnt: part_cnt});
        part_lhs = '0; part_rhs = '0; part_cnt = 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [VW-1:0] hold_l;
    logic [CW-1:0] hold_c;
    rst_n = 1'b0; in_valid = 0; in_last = 0; out_ready = 0; in_lhs = '0; in_rhs = '0;
    model_clear();
    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    // Full vector, lhs = index, rhs = 2.0.
    for (int i = 0; i < VS; i++) step("full", 1, 32'(i), 32'h4000_0000, 0, 1);
    step("full_drain", 0, '0, '0, 0, 1);

    // Short vector with padding.
    for (int i = 0; i < 3; i++) step("short", 1, 32'h3F80_0000, 32'h3F80_0000, i == 2, 0);
    step("short_hold", 0, '0, '0, 0, 1);

    // Backpressure: two full vectors with no consumer.
    for (int i = 0; i < 2 * VS; i++) step("bp", 1, $urandom, $urandom, 0, 0);
    step("bp_pulse", 0, '0, '0, 0, 1);
    step("bp_next", 0, '0, '0, 0, 0);
    step("bp_refill", 1, $urandom, $urandom, 0, 0);
    for (int i = 1; i < VS; i++) step("bp_fill2", 1, $urandom, $urandom, 0, 0);

    // Stall with both banks full; in_valid pulses must be ignored.
    hold_l = out_lhs; hold_c = out_count;
    for (int i = 0; i < 10; i++) step("stall", i[0], $urandom, $urandom, 1, 0);
    check("stall_lhs_const", 1024'(out_lhs), 1024'(hold_l));
    check("stall_cnt_const", 1024'(out_count), 1024'(hold_c));
    step("drain1", 0, '0, '0, 0, 1);
    step("drain2", 0, '0, '0, 0, 1);

    // Reset mid-vector, asserted between edges.
    for (int i = 0; i < 5; i++) step("pre_rst", 1, $urandom, $urandom, 0, 0);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < VS; i++) step("post_rst", 1, $urandom, $urandom, 0, 0);
    step("post_rst_take", 0, '0, '0, 0, 1);

    // Bit-exact special values.
    step("nan_inf", 1, 32'h7FC0_0001, 32'hFF80_0000, 1, 0);
    step("nan_inf_take", 0, '0, '0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
